// File: rtl/get_port_pkg.sv
// get_port_pkg: default parameters and channel-index width helper for the get-port arbiter.
package get_port_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int NUM_CH_DEF = 4;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/get_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from ptr with wrap.
module rr_arbiter
    import get_port_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CW     = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CW-1:0]     ptr_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CW-1:0]     idx_o
);

    logic [CW-1:0] c;

    // Walk offsets from farthest to nearest so the closest requester at or after ptr wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        c     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = CW'((int'(ptr_i) + k) % NUM_CH);
            if (en_i && req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end

endmodule

// File: rtl/get_port_arbiter.sv
// get_port_arbiter: flop register file shared by NUM_CH read channels through a round-robin
// arbiter and a single 1-cycle response slot with write-first bypass.
module get_port_arbiter
    import get_port_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int NUM_CH = NUM_CH_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = ch_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*AW-1:0] req_addr,
    output logic [NUM_CH-1:0]    req_ready,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 rsp_valid,
    output logic [CW-1:0]        rsp_ch,
    output logic [WIDTH-1:0]     rsp_data,
    input  logic                 rsp_ready,
    output logic [15:0]          grant_cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]    rsp_ch_q, rsp_ch_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [CW-1:0]    gnt_idx;
    logic [AW-1:0]    rd_addr;
    logic             slot_free;
    logic             accept;

    assign slot_free = !rsp_valid_q || rsp_ready;

    rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (rst_n && slot_free),
        .gnt_o (req_ready),
        .idx_o (gnt_idx)
    );

    always_comb begin
        accept  = |req_ready;
        rd_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ready[i]) rd_addr = req_addr[i*AW +: AW];
        end
        rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
        rsp_ch_d    = accept ? gnt_idx : rsp_ch_q;
        rsp_data_d  = !accept ? rsp_data_q :
                      (wr_en && wr_addr == rd_addr) ? wr_data : mem_q[rd_addr];
        ptr_d       = !accept ? ptr_q :
                      (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CW'(1);
        cnt_d       = cnt_q + 16'(accept);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_data_q  <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            if (wr_en) mem_q[wr_addr] <= wr_data;
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_data_q  <= rsp_data_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ch    = rsp_ch_q;
    assign rsp_data  = rsp_data_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_get_port_arbiter.sv
// tb_get_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_get_port_arbiter;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rsp_valid;
    logic [1:0]    rsp_ch;
    logic [W-1:0]  rsp_data;
    logic          rsp_ready;
    logic [15:0]   grant_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_mem [D];
    int           m_ptr;
    bit           m_rv;
    int           m_rch;
    logic [W-1:0] m_rdata;
    int           m_cnt;

    always #5 clk = ~clk;

    get_port_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .grant_cnt (grant_cnt)
    );

    function automatic int exp_grant();
        if (rst_n !== 1'b1 || (m_rv && rsp_ready !== 1'b1)) return -1;
        for (int c = m_ptr; c < m_ptr + N; c++) begin
            if (req_valid[c % N]) return c % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        return (g < 0) ? '0 : (N'(1) << g);
    endfunction

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic cycle();
        int g;
        logic [AW-1:0] a;
        g = exp_grant();
        if (rst_n !== 1'b1) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_ptr = 0; m_rv = 0; m_rch = 0; m_rdata = '0; m_cnt = 0;
        end else begin
            if (g >= 0) begin
                a       = req_addr[g*AW +: AW];
                m_rdata = (wr_en && wr_addr == a) ? wr_data : m_mem[a];
                m_rv    = 1;
                m_rch   = g;
                m_ptr   = (g + 1) % N;
                m_cnt   = (m_cnt + 1) % 65536;
            end else if (rsp_ready) begin
                m_rv = 0;
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_addr  = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        cycle();
        cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++;
        if (rsp_ch !== 2'd0) begin errors++; $display("FAIL reset_rsp_ch got %0d exp 0", rsp_ch); end
        checks++;
        if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++;
        if (grant_cnt !== 16'h0) begin errors++; $display("FAIL reset_grant_cnt got %0d exp 0", grant_cnt); end
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_basic_read();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF;
        cycle();
        wr_en = 1'b0;
        req_valid = 4'b0001;
        req_addr  = '0;
        req_addr[0 +: AW] = 3'd3;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b exp 0001", req_ready); end
        cycle();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid got %b exp 1", rsp_valid); end
        checks++;
        if (rsp_ch !== 2'd0) begin errors++; $display("FAIL basic_rsp_ch got %0d exp 0", rsp_ch); end
        checks++;
        if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rsp_data got %h exp deadbeef", rsp_data); end
        checks++;
        if (grant_cnt !== 16'd1) begin errors++; $display("FAIL basic_grant_cnt got %0d exp 1", grant_cnt); end
    endtask

    task automatic test_round_robin();
        int ord [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        idle();
        cycle();
        rst_n = 1'b1;
        req_valid = 4'hF;
        req_addr  = 12'($urandom);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (req_ready !== (N'(1) << ord[i]))
                begin errors++; $display("FAIL rr_ready[%0d] got %b exp ch %0d", i, req_ready, ord[i]); end
            cycle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_ch !== 2'(ord[i]))
                begin errors++; $display("FAIL rr_rsp[%0d] got valid %b ch %0d exp valid 1 ch %0d", i, rsp_valid, rsp_ch, ord[i]); end
        end
    endtask

    task automatic test_backpressure();
        idle();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hCAFE0002;
        cycle();
        wr_en = 1'b0;
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 3'd6;
        cycle();
        checks++;
        if (rsp_ch !== 2'd2 || rsp_data !== 32'hCAFE0002)
            begin errors++; $display("FAIL bp_setup got ch %0d data %h exp ch 2 data cafe0002", rsp_ch, rsp_data); end
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, req_ready); end
            cycle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_ch !== 2'd2 || rsp_data !== 32'hCAFE0002)
                begin errors++; $display("FAIL bp_hold[%0d] got v %b ch %0d data %h exp v 1 ch 2 data cafe0002", i, rsp_valid, rsp_ch, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", req_ready); end
        cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd3)
            begin errors++; $display("FAIL bp_release_rsp got v %b ch %0d exp v 1 ch 3", rsp_valid, rsp_ch); end
    endtask

    task automatic test_write_first();
        idle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h0000AAAA;
        cycle();
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 3'd5;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h00001234;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL wf_ready got %b exp 0010", req_ready); end
        cycle();
        checks++;
        if (rsp_ch !== 2'd1 || rsp_data !== 32'h00001234)
            begin errors++; $display("FAIL wf_bypass got ch %0d data %h exp ch 1 data 00001234", rsp_ch, rsp_data); end
        wr_en = 1'b0;
        cycle();
        checks++;
        if (rsp_data !== 32'h00001234) begin errors++; $display("FAIL wf_stored got %h exp 00001234", rsp_data); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin errors++; $display("FAIL rm_ready got %b exp 0000", req_ready); end
        cycle();
        checks++;
        if (rsp_valid !== 1'b0 || grant_cnt !== 16'd0)
            begin errors++; $display("FAIL rm_state got v %b cnt %0d exp v 0 cnt 0", rsp_valid, grant_cnt); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got %b exp 0001", req_ready); end
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int a = 0; a < D; a++) begin
            req_addr[0 +: AW] = AW'(a);
            cycle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0)
                begin errors++; $display("FAIL rm_entry[%0d] got v %b data %h exp v 1 data 0", a, rsp_valid, rsp_data); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(39) != 0);
            req_valid = N'($urandom);
            req_addr  = 12'($urandom);
            wr_en     = 1'($urandom);
            wr_addr   = AW'($urandom);
            wr_data   = $urandom;
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            checks++;
            if (req_ready !== exp_ready())
                begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", i, req_ready, exp_ready()); end
            cycle();
            checks++;
            if (rsp_valid !== m_rv || grant_cnt !== 16'(m_cnt) ||
                (m_rv && (rsp_ch !== 2'(m_rch) || rsp_data !== m_rdata)))
                begin errors++; $display("FAIL rand_rsp[%0d] got v %b ch %0d data %h cnt %0d exp v %b ch %0d data %h cnt %0d",
                    i, rsp_valid, rsp_ch, rsp_data, grant_cnt, m_rv, m_rch, m_rdata, m_cnt); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cnt_wrap();
        rst_n = 1'b0;
        idle();
        cycle();
        rst_n = 1'b1;
        req_valid = 4'hF;
        repeat (65535) cycle();
        checks++;
        if (grant_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_full got %h exp ffff", grant_cnt); end
        cycle();
        checks++;
        if (grant_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", grant_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_backpressure();
        test_write_first();
        test_reset_mid();
        test_random();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/get_port_arbiter.md
GET_PORT_ARBITER -- requirements
Module: get_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 8, number of register entries (power of two, 2..64); AW = clog2(DEPTH).
REQ-003 Parameter NUM_CH, default 4, number of read channels (1..8); CW = max(1, clog2(NUM_CH)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_CH  per-channel read request.
REQ-007 req_addr  input  NUM_CH*AW  per-channel read address; channel i occupies bits [i*AW +: AW].
REQ-008 req_ready  output  NUM_CH  one-hot (or zero) grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 wr_en  input  1  write strobe.
REQ-010 wr_addr  input  AW  write address.
REQ-011 wr_data  input  WIDTH  write data.
REQ-012 rsp_valid  output  1  response held.
REQ-013 rsp_ch  output  CW  channel index of the held response.
REQ-014 rsp_data  output  WIDTH  read data of the held response.
REQ-015 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-016 grant_cnt  output  16  count of accepted requests, wraps 0xFFFF->0.

Function
REQ-017 The block SHALL hold DEPTH entries of WIDTH bits, written when wr_en is high.
REQ-018 The response slot SHALL be free when rsp_valid=0 or (rsp_valid=1 and rsp_ready=1) in the same cycle.
REQ-019 req_ready SHALL be combinational; at most one bit set; all bits zero when the slot is not free.
REQ-020 Grant SHALL be round-robin: search starts at pointer ptr, upward with wrap; the lowest-index requester at or after ptr wins.
REQ-021 After a grant to channel g, ptr SHALL become (g+1) mod NUM_CH; without a grant, ptr SHALL hold.
REQ-022 Read latency SHALL be 1 cycle: an accepted request at edge N sets rsp_valid=1, rsp_ch=g, rsp_data=entry[addr] after edge N.
REQ-023 A write to the address being read in the same cycle SHALL be write-first: rsp_data SHALL equal wr_data.
REQ-024 rsp_ch and rsp_data SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-025 Consume and new grant in the same cycle SHALL replace the response back-to-back with no bubble; consume without grant SHALL clear rsp_valid.
REQ-026 Writes SHALL proceed regardless of the arbitration or response state.
REQ-027 grant_cnt SHALL increment by 1 per accepted request.
REQ-028 A req_addr value is used only in its accept cycle; requesters may change req_addr while not granted.

Reset
REQ-029 While rst_n=0 at a clock edge: all entries 0, rsp_valid=0, rsp_ch=0, rsp_data=0, ptr=0, grant_cnt=0.
REQ-030 req_ready SHALL be all zero while rst_n=0.
REQ-031 Reset mid-operation SHALL drop any held response; no response SHALL appear for requests pending at reset.

Structure
REQ-032 Package get_port_pkg SHALL hold the default parameter constants and a constant function computing CW from NUM_CH.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr, enable; output: one-hot grant and encoded index).
REQ-034 The entry array SHALL be plain flops, with no memory macro.

Verification
REQ-035 Reset, then write entry 3=0xDEADBEEF; ch0 reads addr 3 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_ch=0, rsp_data=0xDEADBEEF, grant_cnt=1.
REQ-036 All 4 channels request continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, one per cycle, with no bubbles.
REQ-037 rsp_ready=0 for 3 cycles with ch2 holding a response -> req_ready=0, rsp fields stable; rsp_ready=1 -> next grant issued the same cycle.
REQ-038 Write addr 5=0x1234 while ch1 reads addr 5 in the same cycle -> rsp_data=0x1234.
REQ-039 Assert rst_n=0 for one cycle while rsp_valid=1 with requests pending -> rsp_valid=0, ptr=0, grant_cnt=0, entries 0 afterward.
REQ-040 Preload grant_cnt via 65535 accepted requests, then one more -> grant_cnt=0.
